// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver: scans NUM_DIGITS common-anode digits,
// blanks the start of every slot against ghosting, and swaps in newly loaded
// display data only at frame boundaries so a frame never mixes old and new digits.
module seven_seg_scanner #(
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 64,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                                                   clock,
    input  logic                                                   resetN,
    input  logic [4*NUM_DIGITS-1:0]                                value,
    input  logic                                                   load,
    input  logic                                                   octal_mode,
    input  logic                                                   lz_blank,
    input  logic [NUM_DIGITS-1:0]                                  digit_en,
    input  logic [NUM_DIGITS-1:0]                                  dp_in,
    output logic [NUM_DIGITS-1:0]                                  an,
    output logic [6:0]                                             seg,
    output logic                                                   dp,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
    output logic                                                   frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    logic [CNT_W-1:0]        slot_q, slot_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    slot_last, frame_wrap;

    logic [4*NUM_DIGITS-1:0] pend_val_q, act_val_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
    logic [NUM_DIGITS-1:0]   pend_en_q, act_en_q;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    fs_q;

    logic [3:0]              field [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   upper_nz;
    logic                    nz_acc;
    logic [3:0]              cur_field;
    logic                    cur_en, cur_dp, cur_sup, show;
    logic [NUM_DIGITS-1:0]   cur_onehot, an_on;
    logic [6:0]              seg_low;
    logic                    dp_lit;

    // Slot counter and digit index next-state; a frame wraps on the last slot of the last digit.
    always_comb begin
        slot_last  = (slot_q == SLOT_LAST);
        frame_wrap = slot_last && (idx_q == IDX_LAST);
        slot_d     = slot_last ? '0 : slot_q + CNT_W'(1);
        idx_d      = idx_q;
        if (slot_last) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Scan position registers.
    // NOTE: every register uses <= so all flops update together from pre-edge values;
    // mixing in = would make results depend on block evaluation order.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            slot_q <= '0;
            idx_q  <= '0;
        end else begin
            slot_q <= slot_d;
            idx_q  <= idx_d;
        end
    end

    // Pending captures every load; active takes pending only at the frame wrap,
    // so a load on the wrap edge itself lands one frame later.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_en_q  <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            act_en_q   <= '0;
        end else begin
            if (load) begin
                pend_val_q <= value;
                pend_dp_q  <= dp_in;
                pend_en_q  <= digit_en;
            end
            if (frame_wrap) begin
                act_val_q <= pend_val_q;
                act_dp_q  <= pend_dp_q;
                act_en_q  <= pend_en_q;
            end
        end
    end

    // Decode the digit under the scan position, including leading-zero suppression.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise an unassigned path would infer a latch.
        cur_field  = '0;
        cur_en     = 1'b0;
        cur_dp     = 1'b0;
        cur_sup    = 1'b0;
        cur_onehot = '0;
        upper_nz   = '0;
        nz_acc     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            field[i] = octal_mode ? {1'b0, act_val_q[3*i +: 3]} : act_val_q[4*i +: 4];
        end
        // upper_nz[i] is set when any digit at position i or above is non-zero.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz_acc      = nz_acc | (field[i] != 4'h0);
            upper_nz[i] = nz_acc;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_field     = field[i];
                cur_en        = act_en_q[i];
                cur_dp        = act_dp_q[i];
                cur_sup       = lz_blank && (i != 0) && !upper_nz[i];
                cur_onehot[i] = 1'b1;
            end
        end
        show    = (slot_q >= BLANK_END) && cur_en && !cur_sup;
        an_on   = show ? cur_onehot : '0;
        an_d    = AN_ACTIVE_LOW ? ~an_on : an_on;
        seg_low = show ? hex_to_seg(cur_field) : 7'h7F;
        seg_d   = SEG_ACTIVE_LOW ? seg_low : ~seg_low;
        dp_lit  = show && cur_dp;
        dp_d    = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
    end

    // Registered pin drives; frame_start rises on the same edge digit_idx returns to 0.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            an_q  <= AN_ACTIVE_LOW ? '1 : '0;
            seg_q <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
            dp_q  <= SEG_ACTIVE_LOW;
            fs_q  <= 1'b0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fs_q  <= frame_wrap;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign digit_idx   = idx_q;
    assign frame_start = fs_q;

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Parametrised time-multiplexed seven-segment display driver for the front panel. It is the successor to the fixed 8-digit hex path. It scans NUM_DIGITS common-anode digits with configurable refresh rate and anti-ghost blanking. It adds octal/hex radix mode, per-digit enable, leading-zero suppression and tear-free frame-synchronous value updates. It sits between Front_Panel register muxing and the board an/seg/dp pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..16)
REFRESH_DIV, 100000, clock cycles per digit slot (>= BLANK_CYCLES+1)
BLANK_CYCLES, 64, cycles at start of each slot with all anodes off
AN_ACTIVE_LOW, 1, anode polarity (1: 0 = digit on)
SEG_ACTIVE_LOW, 1, segment/dp polarity (1: 0 = segment lit)

Ports:
clock  in  1  system clock
resetN  in  1  asynchronous active-low reset
value  in  4*NUM_DIGITS  display value; hex: digit i = value[4i+3:4i]; octal: digit i = value[3i+2:3i]
load  in  1  strobe: capture value, dp_in, digit_en into pending register
octal_mode  in  1  1 = octal digits (upper bits of value ignored), 0 = hex
lz_blank  in  1  1 = suppress leading zeros
digit_en  in  NUM_DIGITS  per-digit enable; 0 forces digit dark
dp_in  in  NUM_DIGITS  decimal point per digit
an  out  NUM_DIGITS  anode drives
seg  out  7  {g,f,e,d,c,b,a}
dp  out  1  decimal point drive
digit_idx  out  $clog2(NUM_DIGITS) (min 1)  digit currently scanned
frame_start  out  1  one-cycle pulse when digit_idx wraps to 0

Behaviour:
- Reset (async, resetN=0): slot counter=0, digit_idx=0, pending/active registers=0, an all inactive, seg all off, dp off, frame_start=0.
- Slot counter counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and digit_idx increments. digit_idx wraps NUM_DIGITS-1 -> 0.
- On that wrap, active register <= pending register and frame_start pulses. The displayed value changes only at frame boundaries, so there is no tearing.
- load=1 on a clock edge: pending <= {value, dp_in, digit_en}. Multiple loads within a frame: the last one wins. A load coincident with the frame wrap: the transfer uses the old pending; the new data appears next frame.
- octal_mode and lz_blank are sampled live, not through pending.
- Slot counter < BLANK_CYCLES: an all inactive, seg/dp off.
- Otherwise the digit at digit_idx is shown, provided it is enabled and not suppressed.
- Leading-zero suppression (lz_blank=1): digit i is blanked if all digits >= i in the active value are 0 and i != 0. Digit 0 is always shown when enabled. The check uses radix-appropriate digit fields.
- Blanked or disabled digit: its anode is still inactive, and seg/dp are off.
- Hex encoding, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. SEG_ACTIVE_LOW=0 inverts.
- Octal mode: the 3-bit field is zero-extended and uses entries 0..7.
- an, seg, dp are registered: they reflect counter/index state one clock after it changes (1-cycle latency). frame_start is registered the same way.
- Exactly one anode is active outside the blanking window, or none if the digit is blanked.
- NUM_DIGITS=1: digit_idx is constant 0 and frame_start pulses every slot.

Test Plan:
- Reset mid-scan: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1; assert resetN low during slot 2 -> next cycle an=4'b1111, seg=7'b1111111, dp=1, digit_idx=0.
- Hex scan: load value=16'hA7F0, digit_en=4'hF, dp_in=0 -> after frame_start, digit 0 shows seg=1000000, digit 1 shows 0001110, digit 2 shows 1111000, digit 3 shows 0001000. Each digit is lit for 3 cycles after 1 blank cycle; an walks 1110, 1101, 1011, 0111.
- Octal mode: octal_mode=1, value=16'h01C7 (octal fields 7,0,7,0) -> digits show 7,0,7,0 (1111000/1000000 alternating).
- Leading zeros: lz_blank=1, value=16'h0030 -> digits 3 and 2 dark (an stays 1111 in their slots), digit 1 shows 3 (0110000), digit 0 shows 0. value=0 -> only digit 0 shows 0.
- Tear-free update: load 16'h1111, then load 16'h2222 mid-frame -> remaining slots of that frame still show 1. The frame after frame_start shows 2. A load on the wrap cycle is deferred one frame.
- Enables/dp: digit_en=4'b0101, dp_in=4'b0001 -> digits 1 and 3 dark; dp=0 (lit) only in the digit 0 slot.
